// File: rtl/serdes_encrypt_scheduler.sv
// -----------------------------------------------------------------------------
// serdes_encrypt_scheduler
//
// Purpose: arbitrates between two requester channels and runs one fixed-latency
// frame at a time through a bit-serial encryptor core. Each frame is 20 cycles:
//   t0      START : ack[winner] and core_start pulse
//   t1..t8  SHIFT : operand bytes are sent MSB first on core_a_bit/core_b_bit
//   t9,t10  ENC   : serial operand lines are held at 0 while the core works
//   t11..t18 CAPT : core_cipher is shifted in (first sample ends up in bit 7);
//                   core_done is sampled only at t18
//   t19     RESP  : rsp_valid pulse with rsp_ch/rsp_data/rsp_err
// The scheduler is back in IDLE at t20, so grants are at least 21 cycles apart.
//
// Handshake: req[i] is a level that the requester holds (with stable operands)
// until it sees ack[i]; the scheduler samples req only in IDLE, so a request
// dropped before that sample is ignored and changes while busy have no effect.
// ack is a one-cycle one-hot pulse. rsp_valid is a one-cycle pulse with no
// backpressure; rsp_ch/rsp_data/rsp_err hold until the next response.
//
// Configuration macro: SCHED_FIXED_PRIO_EN
//   undefined : round-robin; the last-grant pointer resets to channel 1 so
//               channel 0 wins the first contention.
//   defined   : channel 0 always wins contention; no pointer is kept.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req[NCH]                         per-channel request level
//   a_byte0, b_byte0, a_byte1, b_byte1  channel operand bytes
//   ack[NCH]                         one-hot grant pulse
//   core_start, core_a_bit, core_b_bit  registered strobes/bits to the core
//   core_cipher, core_done           serial cipher and done flag from the core
//   rsp_valid, rsp_ch, rsp_data, rsp_err  response to the requester side
//   busy                             high whenever the FSM is not IDLE
//   dbg_state                        current FSM state encoding
// -----------------------------------------------------------------------------
module serdes_encrypt_scheduler #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [7:0]     a_byte0,
  input  logic [7:0]     b_byte0,
  input  logic [7:0]     a_byte1,
  input  logic [7:0]     b_byte1,
  output logic [NCH-1:0] ack,
  output logic           core_start,
  output logic           core_a_bit,
  output logic           core_b_bit,
  input  logic           core_cipher,
  input  logic           core_done,
  output logic           rsp_valid,
  output logic           rsp_ch,
  output logic [7:0]     rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_ENC   = 3'd3,
    S_CAPT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] cnt;      // cycle index within SHIFT / ENC / CAPT
  logic       win;      // arbitration winner for this IDLE cycle
  logic       ch_lat;   // channel of the frame in flight
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [6:0] cap_sh;   // first seven cipher samples; the eighth goes straight to rsp_data
  logic       grant;

  assign grant = (state == S_IDLE) && (|req);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    win = req[0] ? 1'b0 : 1'b1;
  end
`else
  logic last;  // channel granted most recently

  always_comb begin
    if (req[0] && req[1]) win = ~last;
    else                  win = req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last <= 1'b1;
    else if (grant) last <= win;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == S_IDLE)) cnt <= 3'd0;
      else                                            cnt <= cnt + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (|req)        next_state = S_START;
      S_START:                  next_state = S_SHIFT;
      S_SHIFT: if (cnt == 3'd7) next_state = S_ENC;
      S_ENC:   if (cnt == 3'd1) next_state = S_CAPT;
      S_CAPT:  if (cnt == 3'd7) next_state = S_RESP;
      S_RESP:                   next_state = S_IDLE;
      default:                  next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ack = '0;
    if (state == S_START) ack[ch_lat] = 1'b1;
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath. The core-facing outputs are registered off next_state so they
  // line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_lat     <= 1'b0;
      a_sh       <= 8'd0;
      b_sh       <= 8'd0;
      cap_sh     <= 7'd0;
      core_start <= 1'b0;
      core_a_bit <= 1'b0;
      core_b_bit <= 1'b0;
      rsp_ch     <= 1'b0;
      rsp_data   <= 8'd0;
      rsp_err    <= 1'b0;
    end else begin
      core_start <= (next_state == S_START);

      if (grant) begin
        ch_lat <= win;
        a_sh   <= win ? a_byte1 : a_byte0;
        b_sh   <= win ? b_byte1 : b_byte0;
      end else if (next_state == S_SHIFT) begin
        a_sh <= {a_sh[6:0], 1'b0};
        b_sh <= {b_sh[6:0], 1'b0};
      end

      if (next_state == S_SHIFT) begin
        core_a_bit <= a_sh[7];
        core_b_bit <= b_sh[7];
      end else begin
        core_a_bit <= 1'b0;
        core_b_bit <= 1'b0;
      end

      if (state == S_CAPT) begin
        cap_sh <= {cap_sh[5:0], core_cipher};
        // t18: last cipher bit and the only cycle core_done is trusted
        if (cnt == 3'd7) begin
          rsp_data <= {cap_sh, core_cipher};
          rsp_err  <= ~core_done;
          rsp_ch   <= ch_lat;
        end
      end
    end
  end

endmodule
